// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N:1 channel multiplexer with manual and scan modes.
// Manual mode takes the channel from s. Scan mode visits every channel in
// turn and stays on each one for DWELL enabled cycles. Only the last cycle
// of each dwell period is flagged as a qualified sample.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   i     - flattened channel data, channel k = i[k*W +: W]
//   s     - manual channel select
//   mode  - 0 = manual, 1 = scan
//   en    - clock enable; 0 freezes all state
//   y     - registered selected data
//   ch    - channel index that produced y
//   valid - y is a qualified sample
//   wrap  - one-cycle pulse on the qualified sample of channel N-1 (scan)
//
// state | meaning
// MAN   | manual selection from s (reset state)
// SCAN  | round-robin scan, ptr = channel, dcnt = cycles spent on it
module mux_scan_n #(
    parameter int SW    = 3,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(2**SW)*W-1:0]  i,
    input  logic [SW-1:0]         s,
    input  logic                  mode,
    input  logic                  en,
    output logic [W-1:0]          y,
    output logic [SW-1:0]         ch,
    output logic                  valid,
    output logic                  wrap
);

    localparam int N  = 2**SW;
    // Keep the dwell counter at least one bit wide so DWELL=1 still elaborates.
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DWELL - 1);

    typedef enum logic {
        MAN  = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [SW-1:0] ptr, ptr_nxt;
    logic [DW-1:0] dcnt, dcnt_nxt;
    logic [W-1:0]  y_nxt;
    logic [SW-1:0] ch_nxt;
    logic          valid_nxt;
    logic          wrap_nxt;
    logic          last;

    logic [W-1:0]  chan [N];

    always_comb begin
        for (int k = 0; k < N; k++) begin
            chan[k] = i[k*W +: W];
        end
    end

    assign last = (dcnt == DLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MAN;
            ptr   <= '0;
            dcnt  <= '0;
            y     <= '0;
            ch    <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            dcnt  <= dcnt_nxt;
            y     <= y_nxt;
            ch    <= ch_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        dcnt_nxt  = dcnt;
        y_nxt     = y;
        ch_nxt    = ch;
        valid_nxt = 1'b0;
        wrap_nxt  = 1'b0;

        if (en) begin
            if (!mode) begin
                // Manual sample; also the exit path out of SCAN.
                state_nxt = MAN;
                y_nxt     = chan[s];
                ch_nxt    = s;
                valid_nxt = 1'b1;
            end else if (state == MAN) begin
                // Scan entry: restart from channel 0, no qualified sample yet.
                state_nxt = SCAN;
                ptr_nxt   = '0;
                dcnt_nxt  = '0;
                y_nxt     = chan[0];
                ch_nxt    = '0;
            end else begin
                y_nxt     = chan[ptr];
                ch_nxt    = ptr;
                valid_nxt = last;
                wrap_nxt  = last && (ptr == {SW{1'b1}});
                if (last) begin
                    dcnt_nxt = '0;
                    ptr_nxt  = ptr + 1'b1;
                end else begin
                    dcnt_nxt = dcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mux_scan_n.sv
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        rst, en, mode;
    logic [2:0]  s;
    logic [1:0]  s2;
    logic [7:0]  i1;
    logic [15:0] i2;
    logic [0:0]  y1;
    logic [2:0]  ch1;
    logic        valid1, wrap1;
    logic [3:0]  y2;
    logic [1:0]  ch2;
    logic        valid2, wrap2;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mux_scan_n #(.SW(3), .W(1), .DWELL(4)) dut (
        .clk(clk), .rst(rst), .i(i1), .s(s), .mode(mode), .en(en),
        .y(y1), .ch(ch1), .valid(valid1), .wrap(wrap1)
    );

    mux_scan_n #(.SW(2), .W(4), .DWELL(1)) dut2 (
        .clk(clk), .rst(rst), .i(i2), .s(s2), .mode(mode), .en(en),
        .y(y2), .ch(ch2), .valid(valid2), .wrap(wrap2)
    );

    // Behavioural model: scan position derived from the number of enabled
    // scan cycles since entry (t), not from a pointer/counter pair.
    typedef struct {
        bit       scanning;
        int       t;
        logic [3:0] y;
        int       ch;
        logic     valid;
        logic     wrap;
    } mdl_t;

    mdl_t m1, m2;

    function automatic logic [3:0] pick(logic [15:0] din, int c, int w);
        logic [15:0] sh;
        sh = din >> (c * w);
        return (w == 1) ? {3'b000, sh[0]} : sh[3:0];
    endfunction

    function automatic mdl_t mstep(mdl_t m, bit r, bit e, bit md, int sel,
                                   logic [15:0] din, int n, int d, int w);
        mdl_t q;
        int   c;
        q = m;
        q.valid = 1'b0;
        q.wrap  = 1'b0;
        if (r) begin
            q.scanning = 0; q.t = 0; q.y = '0; q.ch = 0;
        end else if (e) begin
            if (!md) begin
                q.scanning = 0;
                q.ch = sel;
                q.y = pick(din, sel, w);
                q.valid = 1'b1;
            end else if (!q.scanning) begin
                q.scanning = 1;
                q.t = 0;
                q.ch = 0;
                q.y = pick(din, 0, w);
            end else begin
                q.t = q.t + 1;
                c = ((q.t - 1) / d) % n;
                q.ch = c;
                q.y = pick(din, c, w);
                q.valid = (q.t % d) == 0;
                q.wrap = q.valid && (c == n - 1);
            end
        end
        return q;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(bit r, bit e, bit md, int sel);
        rst = r; en = e; mode = md;
        s = 3'(sel); s2 = 2'(sel % 4);
        @(posedge clk);
        m1 = mstep(m1, r, e, md, sel, {8'h00, i1}, 8, 4, 1);
        m2 = mstep(m2, r, e, md, sel % 4, i2, 4, 1, 4);
        #1;
        chk("m1_y", int'(y1), int'(m1.y[0]));
        chk("m1_ch", int'(ch1), m1.ch);
        chk("m1_valid", int'(valid1), int'(m1.valid));
        chk("m1_wrap", int'(wrap1), int'(m1.wrap));
        chk("m2_y", int'(y2), int'(m2.y));
        chk("m2_ch", int'(ch2), m2.ch);
        chk("m2_valid", int'(valid2), int'(m2.valid));
        chk("m2_wrap", int'(wrap2), int'(m2.wrap));
    endtask

    typedef struct {
        bit       r, e, md;
        int       sel;
        bit       ey;
        int       ech;
        bit       ev, ew;
    } vec_t;

    vec_t vt [14];
    logic [3:0] pat2 [4];

    initial begin
        m1 = '{0, 0, 4'h0, 0, 1'b0, 1'b0};
        m2 = m1;
        rst = 1'b1; en = 1'b1; mode = 1'b1; s = '0; s2 = '0;
        i1 = 8'b1010_0110;
        i2 = 16'hC3A5;
        pat2[0] = 4'h5; pat2[1] = 4'hA; pat2[2] = 4'h3; pat2[3] = 4'hC;

        // Reset, scan entry, manual sweep, disabled hold.
        vt[0]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 1, 0, 0, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 0, 0, 0, 1, 0};
        vt[4]  = '{0, 1, 0, 1, 1, 1, 1, 0};
        vt[5]  = '{0, 1, 0, 2, 1, 2, 1, 0};
        vt[6]  = '{0, 1, 0, 3, 0, 3, 1, 0};
        vt[7]  = '{0, 1, 0, 4, 0, 4, 1, 0};
        vt[8]  = '{0, 1, 0, 5, 1, 5, 1, 0};
        vt[9]  = '{0, 1, 0, 6, 0, 6, 1, 0};
        vt[10] = '{0, 1, 0, 7, 1, 7, 1, 0};
        vt[11] = '{0, 0, 0, 3, 1, 7, 0, 0};
        vt[12] = '{0, 0, 1, 2, 1, 7, 0, 0};
        vt[13] = '{0, 1, 0, 2, 1, 2, 1, 0};

        @(negedge clk);
        for (int k = 0; k < 14; k++) begin
            step(vt[k].r, vt[k].e, vt[k].md, vt[k].sel);
            chk("tbl_y", int'(y1), int'(vt[k].ey));
            chk("tbl_ch", int'(ch1), vt[k].ech);
            chk("tbl_valid", int'(valid1), int'(vt[k].ev));
            chk("tbl_wrap", int'(wrap1), int'(vt[k].ew));
        end

        // Full scan sweep over two wraps.
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("entry_valid", int'(valid1), 0);
        chk("entry_ch", int'(ch1), 0);
        chk("entry2_y", int'(y2), 5);
        for (int k = 1; k <= 64; k++) begin
            step(0, 1, 1, 0);
            chk("sweep_valid", int'(valid1), int'(k % 4 == 0));
            chk("sweep_wrap", int'(wrap1), int'(k == 32 || k == 64));
            if (k % 4 == 0) begin
                chk("sweep_ch", int'(ch1), (k / 4 - 1) % 8);
                chk("sweep_y", int'(y1), int'(i1[(k / 4 - 1) % 8]));
            end
            chk("sw2_y", int'(y2), int'(pat2[(k - 1) % 4]));
            chk("sw2_valid", int'(valid2), 1);
            chk("sw2_wrap", int'(wrap2), int'((k - 1) % 4 == 3));
        end

        // Pause at E+6 for three cycles.
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        for (int k = 1; k <= 5; k++) step(0, 1, 1, 0);
        for (int k = 6; k <= 8; k++) begin
            step(0, 0, 1, 0);
            chk("pause_valid", int'(valid1), 0);
            chk("pause_ch", int'(ch1), 1);
            chk("pause_y", int'(y1), 1);
        end
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("pre_resume_valid", int'(valid1), 0);
        step(0, 1, 1, 0);
        chk("resume_valid", int'(valid1), 1);
        chk("resume_ch", int'(ch1), 1);

        // Mid-scan manual sample, re-entry, then reset mid-scan.
        step(1, 1, 1, 0);
        step(0, 1, 1, 0);
        for (int k = 1; k <= 9; k++) step(0, 1, 1, 0);
        step(0, 1, 0, 6);
        chk("mid_y", int'(y1), 0);
        chk("mid_ch", int'(ch1), 6);
        chk("mid_valid", int'(valid1), 1);
        step(0, 1, 1, 0);
        chk("reentry_valid", int'(valid1), 0);
        chk("reentry_ch", int'(ch1), 0);
        for (int k = 1; k <= 4; k++) step(0, 1, 1, 0);
        chk("reentry_first_valid", int'(valid1), 1);
        chk("reentry_first_ch", int'(ch1), 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(1, 1, 1, 0);
        chk("midrst_ch", int'(ch1), 0);
        chk("midrst_valid", int'(valid1), 0);
        chk("midrst_y2", int'(y2), 0);

        // Randomised run against the model.
        for (int k = 0; k < 4000; k++) begin
            i1 = 8'($urandom);
            i2 = 16'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 63) != 0, int'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N:1 multiplexer with two modes. In manual mode, software selects the channel. In scan mode, a built-in round-robin sequencer visits every channel for a programmable dwell time. It succeeds the fixed 8:1 combinational mux as the channel-selection stage in front of sampling and monitoring logic. It adds configurable channel count and width, a registered output, and channel/valid/wrap status.

## Interface
Parameters:
- SW, 3: select width; channel count N = 2**SW (SW ≥ 1).
- W, 1: data width per channel.
- DWELL, 4: cycles spent on each channel in scan mode (DWELL ≥ 1).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- i  input  N*W  flattened channel data; channel k = i[k*W +: W].
- s  input  SW  channel select, used in manual mode.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  clock enable; 0 freezes the block.
- y  output  W  registered selected data.
- ch  output  SW  channel index that produced the current y.
- valid  output  1  y is a qualified sample (manual: every enabled cycle; scan: last dwell cycle only).
- wrap  output  1  one-cycle pulse marking the qualified sample of channel N-1 in scan mode.

## Operation
- States: MAN (reset state) and SCAN. Internal registers are ptr[SW-1:0] and dwell counter dcnt, sized to hold 0..DWELL-1.
- rst=1: state=MAN, y=0, ch=0, valid=0, wrap=0, ptr=0, dcnt=0. Reset overrides en and mode.
- en=0, any state: state, ptr, dcnt, y and ch hold. valid=0, wrap=0.
- MAN, en=1, mode=0: y←i[s], ch←s, valid←1, wrap←0. Remains in MAN.
- MAN, en=1, mode=1 (scan entry cycle):
  - state←SCAN, ptr←0, dcnt←0.
  - y←i[0], ch←0, valid←0, wrap←0.
- SCAN, en=1, mode=1:
  - y←i[ptr], ch←ptr.
  - valid←(dcnt==DWELL-1).
  - wrap←(dcnt==DWELL-1 && ptr==N-1).
  - If dcnt==DWELL-1: dcnt←0 and ptr←ptr+1, where ptr wraps from N-1 to 0 by natural SW-bit overflow. Otherwise dcnt←dcnt+1.
- SCAN, en=1, mode=0: state←MAN and a manual sample is taken in the same cycle (y←i[s], ch←s, valid←1, wrap←0). ptr and dcnt are not used again until the next scan entry clears them.
- DWELL=1: in SCAN, valid=1 every cycle and ptr advances every cycle.
- en=0 in SCAN pauses the dwell count. Scanning resumes from the frozen ptr/dcnt when en returns with mode=1.
- i is sampled only at the clock edge. Changes to i within a dwell period appear on y on the next edge.

## Timing
- Latency is 1 cycle from input/select to y/ch/valid/wrap. There is no combinational path from inputs to outputs.
- Scan entry: the entry edge E produces no valid. The first valid (ch=0) occurs at edge E+DWELL. The valid for channel k occurs at E+(k+1)·DWELL.
- A full sweep takes N·DWELL enabled cycles after entry. wrap occurs at E+N·DWELL, coincident with valid for ch=N-1, then repeats every N·DWELL enabled cycles.
- Disabled cycles (en=0) stretch all of the above by exactly the number of disabled cycles.
- Mode changes take effect on the first edge at which the new mode is sampled with en=1.

## Test plan
Configuration: N=8, W=1, DWELL=4, i=8'b1010_0110 unless stated otherwise.
- Reset: hold rst=1 for 2 edges with en=1, mode=1 → y=0, ch=0, valid=0, wrap=0. First edge after release with mode=1 is a scan entry: ch=0, valid=0.
- Manual sweep: mode=0, en=1, s=0..7 on successive edges → one cycle later y=0,1,1,0,0,1,0,1, ch tracks s, valid=1 every cycle.
- Scan sweep: entry at edge E →
  - valid only at E+4, E+8, …, E+32.
  - Those valid samples carry ch=0..7 and y=i[ch].
  - wrap=1 only at E+32; next wrap at E+64.
- Pause/resume: mode=1, drop en for 3 cycles at E+6 →
  - y, ch held and valid=0 during the pause.
  - The ch=1 valid moves from E+8 to E+11.
- Mid-scan events:
  - mode=0 with s=6 at E+10 → y=0, ch=6, valid=1 on the next edge.
  - mode=1 again → new entry cycle, restarting at ch=0.
  - rst at any scan point → all outputs 0 on the following edge.
- Width/size: SW=2, W=4, DWELL=1, i=16'hC3A5 (channel k = i[4k+3:4k]) →
  - Each enabled scan edge gives valid=1 with y=5,A,3,C cycling.
  - wrap=1 every 4th edge, alongside y=C.
